// File: rtl/wb_arbiter_if.sv
// Bus bundle between decode/EXU/LSU and the register-file write-side arbiter.
// The forwarding signals exist only when WB_FORWARD_EN is defined.
interface wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned AW = 5;

    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    logic            exu_valid;
    logic            exu_ready;
    logic [AW-1:0]   exu_rd;
    logic [XLEN-1:0] exu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   raddr1;
    logic [AW-1:0]   raddr2;
    logic            hazard1;
    logic            hazard2;
    logic            sb_err;
`ifdef WB_FORWARD_EN
    logic            fwd1;
    logic            fwd2;
    logic [XLEN-1:0] fwd_data;
`endif

    modport slave (
        input  iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
               lsu_valid, lsu_rd, lsu_data, raddr1, raddr2,
        output iss_ready, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
               hazard1, hazard2, sb_err
`ifdef WB_FORWARD_EN
        , output fwd1, fwd2, fwd_data
`endif
    );

    modport master (
        output iss_valid, iss_rd, exu_valid, exu_rd, exu_data,
               lsu_valid, lsu_rd, lsu_data, raddr1, raddr2,
        input  iss_ready, exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata,
               hazard1, hazard2, sb_err
`ifdef WB_FORWARD_EN
        , input fwd1, fwd2, fwd_data
`endif
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-side arbiter: round-robin EXU/LSU writeback plus busy scoreboard.
// Define WB_FORWARD_EN to add write-cycle forwarding (fwd1/fwd2/fwd_data).
module wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned AW = 5;

    typedef enum logic {
        GNT_EXU = 1'b0,
        GNT_LSU = 1'b1
    } grant_t;

    grant_t          last_grant;
    grant_t          last_grant_nxt;
    logic            gnt_exu;
    logic            gnt_lsu;
    logic            gnt_any;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            iss_fire;

    logic            rf_wen_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic            sb_err_q;

    logic            raw1;
    logic            raw2;

    // Round-robin grant state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant <= GNT_EXU;
        else     last_grant <= last_grant_nxt;
    end

    // Grant select: a lone requester wins, contention goes to the one not served last
    always_comb begin
        gnt_exu        = 1'b0;
        gnt_lsu        = 1'b0;
        last_grant_nxt = last_grant;
        if (bus.exu_valid && bus.lsu_valid) begin
            if (last_grant == GNT_EXU) gnt_lsu = 1'b1;
            else                       gnt_exu = 1'b1;
        end else if (bus.exu_valid) begin
            gnt_exu = 1'b1;
        end else if (bus.lsu_valid) begin
            gnt_lsu = 1'b1;
        end
        if (gnt_exu) last_grant_nxt = GNT_EXU;
        if (gnt_lsu) last_grant_nxt = GNT_LSU;
    end

    assign gnt_any  = gnt_exu | gnt_lsu;
    assign sel_rd   = gnt_lsu ? bus.lsu_rd   : bus.exu_rd;
    assign sel_data = gnt_lsu ? bus.lsu_data : bus.exu_data;

    // Registered write port and sticky scoreboard error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            rf_wen_q <= gnt_any && (sel_rd != '0);
            if (gnt_any) begin
                rf_waddr_q <= sel_rd;
                rf_wdata_q <= sel_data;
            end
            if (gnt_any && (sel_rd != '0) && !busy[sel_rd]) sb_err_q <= 1'b1;
        end
    end

    assign bus.iss_ready = (bus.iss_rd == '0) || !busy[bus.iss_rd];
    assign iss_fire      = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);

    // Scoreboard: clear on the write edge, set on issue (set wins), r0 never busy
    always_comb begin
        busy_nxt = busy;
        if (rf_wen_q) busy_nxt[rf_waddr_q] = 1'b0;
        if (iss_fire) busy_nxt[bus.iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    assign raw1 = (bus.raddr1 != '0) && busy[bus.raddr1];
    assign raw2 = (bus.raddr2 != '0) && busy[bus.raddr2];

`ifdef WB_FORWARD_EN
    logic fwd1;
    logic fwd2;
    assign fwd1         = rf_wen_q && (rf_waddr_q == bus.raddr1) && (bus.raddr1 != '0);
    assign fwd2         = rf_wen_q && (rf_waddr_q == bus.raddr2) && (bus.raddr2 != '0);
    assign bus.fwd1     = fwd1;
    assign bus.fwd2     = fwd2;
    assign bus.fwd_data = rf_wdata_q;
    assign bus.hazard1  = raw1 && !fwd1;
    assign bus.hazard2  = raw2 && !fwd2;
`else
    assign bus.hazard1  = raw1;
    assign bus.hazard2  = raw2;
`endif

    assign bus.exu_ready = gnt_exu;
    assign bus.lsu_ready = gnt_lsu;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.sb_err    = sb_err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: write-port scoreboard queue plus inline checks
// of ready, hazard, scoreboard and reset behaviour.
module tb_wb_arbiter;
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Write-port monitor: every rf_wen cycle must match the oldest expected write
    always @(negedge clk) begin
        if (bus.rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h/%h expected=none t=%0t",
                         bus.rf_waddr, bus.rf_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_addr", 32'(bus.rf_waddr), 32'(e.addr));
                chk("wb_data", bus.rf_wdata, e.data);
            end
        end
    end

    initial begin
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.exu_valid = 1'b0; bus.exu_rd = '0; bus.exu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
        bus.raddr1 = 5'd5; bus.raddr2 = 5'd5;

        // Reset values seen before any clock edge
        #2;
        chk("rst_wen",    32'(bus.rf_wen), 32'd0);
        chk("rst_waddr",  32'(bus.rf_waddr), 32'd0);
        chk("rst_wdata",  bus.rf_wdata, 32'd0);
        chk("rst_sberr",  32'(bus.sb_err), 32'd0);
        chk("rst_haz1",   32'(bus.hazard1), 32'd0);
        chk("rst_issrdy", 32'(bus.iss_ready), 32'd1);
        tick(); tick();
        rst = 1'b0;

        // Issue r5, then EXU writes 0xDEADBEEF to r5
        tick(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
        mid();  chk("iss5_ready", 32'(bus.iss_ready), 32'd1);
        tick(); bus.iss_valid = 1'b0;
                bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'hDEADBEEF;
                exp_q.push_back('{5'd5, 32'hDEADBEEF});
        mid();  chk("r5_haz1_pend", 32'(bus.hazard1), 32'd1);
                chk("r5_exu_ready", 32'(bus.exu_ready), 32'd1);
                chk("r5_lsu_ready", 32'(bus.lsu_ready), 32'd0);
                chk("r5_wen_pre",   32'(bus.rf_wen), 32'd0);
        tick(); bus.exu_valid = 1'b0;
        mid();
`ifdef WB_FORWARD_EN
                chk("r5_haz2_wcyc", 32'(bus.hazard2), 32'd0);
                chk("r5_fwd2",      32'(bus.fwd2), 32'd1);
                chk("r5_fwd_data",  bus.fwd_data, 32'hDEADBEEF);
`else
                chk("r5_haz2_wcyc", 32'(bus.hazard2), 32'd1);
                chk("r5_haz1_wcyc", 32'(bus.hazard1), 32'd1);
`endif
        tick(); bus.iss_rd = 5'd5;
        mid();  chk("r5_haz1_done", 32'(bus.hazard1), 32'd0);
                chk("r5_iss_ready", 32'(bus.iss_ready), 32'd1);
                chk("r5_wen_post",  32'(bus.rf_wen), 32'd0);

        // WAW on r9: issue blocked until the writeback edge
        tick(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        mid();  chk("waw9_blocked", 32'(bus.iss_ready), 32'd0);
        tick(); bus.exu_valid = 1'b1; bus.exu_rd = 5'd9; bus.exu_data = 32'h0000_0099;
                exp_q.push_back('{5'd9, 32'h0000_0099});
        mid();  chk("waw9_acc_blk", 32'(bus.iss_ready), 32'd0);
        tick(); bus.exu_valid = 1'b0;
        mid();  chk("waw9_wcyc_blk", 32'(bus.iss_ready), 32'd0);
        tick(); bus.iss_valid = 1'b0;
        mid();  chk("waw9_free", 32'(bus.iss_ready), 32'd1);

        // rd=0 result consumes a grant but never writes
        tick(); bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'h0000_1234;
        mid();  chk("rd0_ready", 32'(bus.exu_ready), 32'd1);
        tick(); bus.exu_valid = 1'b0;
        mid();  chk("rd0_wen", 32'(bus.rf_wen), 32'd0);
                chk("rd0_sberr", 32'(bus.sb_err), 32'd0);

        // Result for non-busy r12: written and flags sb_err
        tick(); bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd12; bus.lsu_data = 32'h00C0_FFEE;
                exp_q.push_back('{5'd12, 32'h00C0_FFEE});
        mid();  chk("r12_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        tick(); bus.lsu_valid = 1'b0;
        mid();  chk("r12_sberr", 32'(bus.sb_err), 32'd1);
        tick(); tick();
        mid();  chk("r12_sberr_sticky", 32'(bus.sb_err), 32'd1);

        // Async reset in the middle of an r20 write cycle
        tick(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd20; bus.raddr1 = 5'd20;
        tick(); bus.iss_valid = 1'b0;
                bus.exu_valid = 1'b1; bus.exu_rd = 5'd20; bus.exu_data = 32'h2020_2020;
        mid();  chk("r20_haz1", 32'(bus.hazard1), 32'd1);
        tick(); bus.exu_valid = 1'b0;
        #1;     chk("r20_wen_pre", 32'(bus.rf_wen), 32'd1);
        rst = 1'b1;
        #1;     chk("arst_wen",    32'(bus.rf_wen), 32'd0);
                chk("arst_haz1",   32'(bus.hazard1), 32'd0);
                chk("arst_sberr",  32'(bus.sb_err), 32'd0);
                chk("arst_issrdy", 32'(bus.iss_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        mid();  chk("arst_no_write", 32'(bus.rf_wen), 32'd0);

        // Contention after reset: LSU first, then EXU, back-to-back writes
        tick(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
        tick(); bus.iss_rd = 5'd7;
        tick(); bus.iss_valid = 1'b0;
                bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 32'h0000_0011;
                bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h0000_0022;
                exp_q.push_back('{5'd7, 32'h0000_0022});
        mid();  chk("cont_lsu_first", 32'(bus.lsu_ready), 32'd1);
                chk("cont_exu_wait",  32'(bus.exu_ready), 32'd0);
        tick(); bus.lsu_valid = 1'b0;
                exp_q.push_back('{5'd3, 32'h0000_0011});
        mid();  chk("cont_exu_next", 32'(bus.exu_ready), 32'd1);
        tick(); bus.exu_valid = 1'b0;
        mid();  chk("cont_wen_2nd", 32'(bus.rf_wen), 32'd1);
        tick(); tick();
        mid();  chk("cont_sberr", 32'(bus.sb_err), 32'd0);

        tick(); tick();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write side of the 32x32 integer register file: collects results from the EXU and the LSU.
- Arbitrates between them (round-robin) and drives the single register-file write port (wen/waddr/wdata) from registered outputs.
- Keeps a per-register busy scoreboard, set at issue and cleared at writeback, so decode can detect RAW/WAW hazards on its read addresses.

Parameters:
XLEN, 32, data width of results and register file
NREG, 32, number of architectural registers; index width is 5 (fixed, NREG must be 32)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
iss_valid  input  1  decode issues an instruction that will write iss_rd
iss_rd  input  5  destination register of issued instruction
iss_ready  output  1  issue may proceed (no WAW on iss_rd)
exu_valid  input  1  EXU result available
exu_ready  output  1  EXU result accepted this cycle
exu_rd  input  5  EXU destination register
exu_data  input  XLEN  EXU result
lsu_valid  input  1  LSU load result available
lsu_ready  output  1  LSU result accepted this cycle
lsu_rd  input  5  LSU destination register
lsu_data  input  XLEN  LSU load data
rf_wen  output  1  register-file write enable
rf_waddr  output  5  register-file write address
rf_wdata  output  XLEN  register-file write data
raddr1  input  5  decode read address 1
raddr2  input  5  decode read address 2
hazard1  output  1  raddr1 has a pending write
hazard2  output  1  raddr2 has a pending write
sb_err  output  1  sticky: result arrived for a register not marked busy

Behaviour:
- Reset (async, rst=1):
  - busy[31:0]=0; rf_wen=0, rf_waddr=0, rf_wdata=0.
  - last_grant=EXU, so the LSU wins the first contention; sb_err=0.
  - Reset mid-operation discards any in-flight grant; no write is emitted after rst is released until a new handshake.
- Issue:
  - iss_ready = (iss_rd==0) | ~busy[iss_rd]. This is combinational from registered state.
  - On iss_valid & iss_ready & iss_rd!=0, busy[iss_rd] is set at the edge.
- Arbitration (combinational grant, one source per cycle):
  - Only one valid: grant that source.
  - Both valid: grant the source not equal to last_grant. last_grant updates only on a grant.
  - exu_ready / lsu_ready equal the respective grant; ready depends combinationally on both valids.
- Accept cycle N (grant to source S):
  - At the edge: rf_wen <= (S.rd!=0), rf_waddr <= S.rd, rf_wdata <= S.data.
  - No grant: rf_wen <= 0; waddr/wdata hold their values.
  - Write-port latency is 1 cycle. The register file commits at the end of cycle N+1.
- Scoreboard clear:
  - busy[rf_waddr] is cleared at the edge ending the cycle in which rf_wen=1, i.e. the same edge the register file writes.
- Set and clear of the same register at the same edge: the set wins. This requires an issue to that register while rf_wen targets it, which iss_ready prevents unless that register is r0; r0 is never set.
- Results with rd=0: accepted and consume the grant; rf_wen stays 0; no scoreboard change.
- A result accepted with rd!=0 and busy[rd]=0 is still written, and sb_err is set. sb_err clears only on reset.
- Hazards: hazardK = (raddrK!=0) & busy[raddrK]. It stays asserted during the write cycle N+1 unless forwarding is enabled.
- busy bit 0 is hardwired 0.

Optional Feature:
Macro WB_FORWARD_EN.
- Defined:
  - Adds outputs fwd1, fwd2 (1 bit each) and fwd_data (XLEN).
  - fwdK = rf_wen & (rf_waddr==raddrK) & (raddrK!=0); fwd_data = rf_wdata.
  - hazardK is suppressed whenever fwdK=1, so decode reads the forwarded value in cycle N+1.
- Undefined:
  - No forwarding ports.
  - hazardK remains 1 through cycle N+1; decode sees the value from cycle N+2 onward.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> rf_wen=0, all hazards 0, sb_err=0, iss_ready=1 immediately, without waiting for an edge.
- Issue rd=5, then EXU result rd=5 data=0xDEADBEEF -> hazard1 on raddr1=5 is 1 until the write cycle. rf_wen=1, waddr=5, wdata=0xDEADBEEF one cycle after accept; busy[5] is clear the following cycle.
- Issue rd=3 and rd=7; EXU (rd=3, 0x11) and LSU (rd=7, 0x22) both valid from reset -> LSU granted first, EXU next cycle. Writes appear in order 7 then 3, back-to-back.
- WAW: issue rd=9, then iss_valid with rd=9 -> iss_ready=0 until the writeback edge of r9, then 1.
- rd=0 result, and result for non-busy r12 -> rd=0: ready=1 but rf_wen=0. r12: written, sb_err=1 sticky.
- WB_FORWARD_EN: raddr2=5 during the r5 write cycle -> fwd2=1, fwd_data=0xDEADBEEF, hazard2=0. Without the macro, hazard2=1 in that cycle.
